acc_share_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing one accumulator datapath (clear/start/in in, cnt/out back) among NREQ requesters.
- Each requester submits a burst of DWIDTH-bit words over a valid/ready handshake.
- Per burst, the block clears the accumulator, streams the granted burst into it, captures the sum and count, and returns them tagged with the requester id.

---
 rtl/acc_share_arb.sv | 169 ++++++++++++++++
 tb/tb_acc_share_arb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_share_arb.sv
// acc_share_arb: round-robin arbiter/sequencer sharing one accumulator among
// NREQ requesters. A granted burst is streamed into a cleared accumulator and
// the resulting sum/count is returned tagged with the requester id.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/last/ready     per-requester beat handshake (one bit each)
//   req_data                 per-requester words, slice i = [i*DWIDTH +: DWIDTH]
//   acc_clear/start/in       accumulator control (decoded from state and gnt)
//   acc_cnt/acc_out          registered accumulator count and sum
//   rsp_valid/id/sum/cnt/trunc  one-cycle result pulse, fields held afterwards
//   busy                     high whenever the sequencer is not idle
module acc_share_arb #(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned DWIDTH = 8,
    parameter  int unsigned VWIDTH = 4,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   acc_clear,
    output logic                   acc_start,
    output logic [DWIDTH-1:0]      acc_in,
    input  logic [VWIDTH-1:0]      acc_cnt,
    input  logic [DWIDTH:0]        acc_out,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DWIDTH:0]        rsp_sum,
    output logic [VWIDTH-1:0]      rsp_cnt,
    output logic                   rsp_trunc,
    output logic                   busy
);
    localparam int unsigned PW = IDW + 1;
    localparam logic [VWIDTH-1:0] MAXLEN = '1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [IDW-1:0]    gnt, gnt_nxt;
    logic [IDW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [VWIDTH-1:0] beat_cnt, beat_cnt_nxt;
    logic              trunc, trunc_nxt;
    logic              rsp_load;
    logic              found;
    logic [IDW-1:0]    pick;
    logic              g_valid, g_last;
    logic [DWIDTH-1:0] g_data;

    // First valid requester searched cyclically from rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int unsigned off = 0; off < NREQ; off++) begin
            logic [PW-1:0] idx;
            idx = {1'b0, rr_ptr} + PW'(off);
            if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    // Granted requester's lane.
    always_comb begin
        g_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) g_data = req_data[i*DWIDTH +: DWIDTH];
        end
        g_valid = req_valid[gnt];
        g_last  = req_last[gnt];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and accumulator/handshake decode.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        trunc_nxt    = trunc;
        rsp_load     = 1'b0;
        req_ready    = '0;
        acc_clear    = 1'b0;
        acc_start    = 1'b0;
        acc_in       = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                acc_clear    = 1'b1;
                beat_cnt_nxt = '0;
                state_nxt    = XFER;
            end
            XFER: begin
                req_ready[gnt] = 1'b1;
                acc_start      = g_valid;
                acc_in         = g_valid ? g_data : '0;
                if (g_valid) begin
                    beat_cnt_nxt = beat_cnt + VWIDTH'(1);
                    // last wins over the length cap when both coincide
                    if (g_last) begin
                        trunc_nxt = 1'b0;
                        state_nxt = WAIT;
                    end else if (beat_cnt == MAXLEN - VWIDTH'(1)) begin
                        trunc_nxt = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                rsp_load  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rr_ptr_nxt = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, beat count and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            trunc     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cnt   <= '0;
            rsp_trunc <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            trunc     <= trunc_nxt;
            rsp_valid <= rsp_load;
            busy      <= (state_nxt != IDLE);
            if (rsp_load) begin
                rsp_id    <= gnt;
                rsp_sum   <= acc_out;
                rsp_cnt   <= acc_cnt;
                rsp_trunc <= trunc;
            end
        end
    end

endmodule

// File: tb/tb_acc_share_arb.sv
// Testbench for acc_share_arb: per-requester word streams drive the request
// ports, a queue-based reference model predicts the response sequence, and a
// monitor pops expectations whenever rsp_valid pulses.
module tb_acc_share_arb;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned DW     = 8;
    localparam int unsigned VW     = 4;
    localparam int unsigned IDW    = 2;
    localparam int unsigned MAXLEN = 15;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW:0]    sum;
        logic [VW-1:0]  cnt;
        logic           trunc;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_last  = '0;
    logic [NREQ*DW-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_ready;
    logic               acc_clear, acc_start;
    logic [DW-1:0]      acc_in;
    logic [VW-1:0]      acc_cnt = '0;
    logic [DW:0]        acc_out = '0;
    logic               rsp_valid, rsp_trunc, busy;
    logic [IDW-1:0]     rsp_id;
    logic [DW:0]        rsp_sum;
    logic [VW-1:0]      rsp_cnt;

    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    int   last_rsp_cyc = 0;
    int   clr_seen = 0;
    bit   prev_rsp = 1'b0;
    bit   stall_en = 1'b0;

    logic [DW:0] strm [NREQ][$];   // {last, data} words still to be offered
    rsp_t        exp_q [$];

    acc_share_arb #(.NREQ(NREQ), .DWIDTH(DW), .VWIDTH(VW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .acc_clear(acc_clear), .acc_start(acc_start), .acc_in(acc_in),
        .acc_cnt(acc_cnt), .acc_out(acc_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cnt(rsp_cnt), .rsp_trunc(rsp_trunc), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External accumulator: deliberately never reset so a missing clear shows up.
    always @(posedge clk) begin
        if (acc_clear) begin
            acc_out <= '0;
            acc_cnt <= '0;
        end else if (acc_start) begin
            acc_out <= acc_out + {1'b0, acc_in};
            acc_cnt <= acc_cnt + VW'(1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit streams_empty();
        for (int i = 0; i < NREQ; i++) if (strm[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_burst(input int i, input int len, input int mode);
        for (int k = 0; k < len; k++) begin
            logic [DW-1:0] d;
            d = (mode == 1) ? DW'(1) : DW'($urandom);
            strm[i].push_back({(k == len - 1), d});
        end
    endtask

    task automatic push_word(input int i, input int d, input bit last);
        strm[i].push_back({last, DW'(d)});
    endtask

    // Reference model: round-robin over non-empty streams; a burst ends on last or after MAXLEN words.
    task automatic build_expected();
        int pos [NREQ];
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        forever begin
            int id;
            int s;
            int n;
            bit tr;
            rsp_t e;
            id = -1;
            for (int off = 0; off < NREQ; off++) begin
                int c;
                c = (model_ptr + off) % NREQ;
                if (id < 0 && pos[c] < strm[c].size()) id = c;
            end
            if (id < 0) break;
            s = 0; n = 0; tr = 1'b0;
            while (pos[id] < strm[id].size()) begin
                logic [DW:0] w;
                w = strm[id][pos[id]];
                pos[id]++;
                s += int'(w[DW-1:0]);
                n++;
                if (w[DW]) break;
                if (n == MAXLEN) begin tr = 1'b1; break; end
            end
            e.id    = IDW'(id);
            e.sum   = (DW+1)'(s % (1 << (DW + 1)));
            e.cnt   = VW'(n);
            e.trunc = tr;
            exp_q.push_back(e);
            model_ptr = (id + 1) % NREQ;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && streams_empty() && !busy)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                tests++;
                errors++;
                $display("FAIL %s timeout: %0d responses outstanding, expected 0", name, exp_q.size());
                exp_q.delete();
                for (int i = 0; i < NREQ; i++) strm[i].delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    // Requester drivers: offer stream heads; optional stalls while granted and drops while not granted.
    initial begin : drv
        logic [NREQ-1:0] fire;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i] && strm[i].size() > 0) void'(strm[i].pop_front());
                if (strm[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[i*DW +: DW] = '0;
                end else if (stall_en && ((req_ready[i] && $urandom_range(3) == 0) ||
                                          (busy && !req_ready[i] && $urandom_range(2) == 0))) begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else begin
                    logic [DW:0] w;
                    w = strm[i][0];
                    req_valid[i] = 1'b1;
                    req_last[i]  = w[DW];
                    req_data[i*DW +: DW] = w[DW-1:0];
                end
            end
        end
    end

    // Monitor: per-cycle handshake checks and scoreboard pops on rsp_valid.
    initial begin : mon
        logic [NREQ-1:0] f;
        logic [DW-1:0]   gd;
        rsp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                clr_seen = 0;
                prev_rsp = 1'b0;
            end else begin
                f  = req_valid & req_ready;
                gd = '0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gd = req_data[i*DW +: DW];
                chk("ready_onehot", 32'($onehot0(req_ready)), 32'(1));
                chk("acc_start", 32'(acc_start), 32'(|f));
                chk("acc_in", 32'(acc_in), (|f) ? 32'(gd) : 32'(0));
                if (acc_clear || (|req_ready)) chk("busy_active", 32'(busy), 32'(1));
                if (acc_clear) clr_seen++;
                if (rsp_valid) begin
                    chk("rsp_one_cycle", 32'(prev_rsp), 32'(0));
                    chk("clear_per_grant", 32'(clr_seen), 32'(1));
                    clr_seen = 0;
                    last_rsp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d sum %0h, expected no response", rsp_id, rsp_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                        chk("rsp_cnt", 32'(rsp_cnt), 32'(e.cnt));
                        chk("rsp_trunc", 32'(rsp_trunc), 32'(e.trunc));
                    end
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_acc_clear"}, 32'(acc_clear), 32'(0));
        chk({tag, "_acc_start"}, 32'(acc_start), 32'(0));
        chk({tag, "_acc_in"},    32'(acc_in),    32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'(0));
        chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'(0));
        chk({tag, "_rsp_cnt"},   32'(rsp_cnt),   32'(0));
        chk({tag, "_rsp_trunc"}, 32'(rsp_trunc), 32'(0));
        chk({tag, "_busy"},      32'(busy),      32'(0));
    endtask

    initial begin : main
        int t0;
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single burst with latency check.
        push_word(1, 3, 1'b0); push_word(1, 5, 1'b0); push_word(1, 7, 1'b1);
        build_expected();
        @(posedge clk);
        #2;
        t0 = cyc;
        wait_done("single", 200);
        chk("latency", 32'(last_rsp_cyc - t0), 32'(6));

        // Sum carry into the extra bit.
        push_word(0, 200, 1'b0); push_word(0, 100, 1'b1);
        build_expected();
        wait_done("carry", 200);

        // Round robin with one-beat bursts on every requester.
        for (int i = 0; i < NREQ; i++) begin push_burst(i, 1, 0); push_burst(i, 1, 0); end
        build_expected();
        wait_done("round_robin", 500);

        // Length boundary: exactly MAXLEN with last, and MAXLEN+1.
        push_burst(0, 15, 0);
        push_burst(1, 16, 0);
        build_expected();
        wait_done("boundary", 500);

        // Truncation: 20 ones without intermediate last.
        push_burst(2, 20, 1);
        build_expected();
        wait_done("truncation", 500);

        // Randomised rounds with stalls and non-granted valid drops.
        stall_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int nb;
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) push_burst(i, $urandom_range(1, 20), 0);
            end
            build_expected();
            wait_done("random", 5000);
        end
        stall_en = 1'b0;

        // Reset in the middle of a transfer.
        push_burst(1, 6, 0);
        n = 0;
        while (strm[1].size() > 4 && n < 100) begin @(negedge clk); n++; end
        chk("reset_reached_xfer", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < NREQ; i++) strm[i].delete();
        exp_q.delete();
        model_ptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_burst(3, 3, 0);
        push_burst(0, 4, 0);
        build_expected();
        wait_done("after_reset", 500);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
